tx_port_gearbox: RTL and testbench
==================================

Name: tx_port_gearbox

Overview:
- Per-port egress adapter. Sits directly downstream of the deparser, one instance per TX port (32 total).
- Accepts 512-bit cells (sof/eof/eop_len framing, tx_ready backpressure) and buffers them in a small cell FIFO.
- Serialises cells into OUT_W-bit beats with byte-keep for the port MAC.
- Counts transmitted packets and detects input framing errors.

Parameters:
DEPTH, 8, cell FIFO depth in 512-bit cells; power of 2, >= 2
OUT_W, 64, MAC beat width in bits; 64 or 128 only
BEATS, 512/OUT_W, derived localparam: beats per cell (8 or 4)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  cell valid from deparser (tx_valid[p])
in_sof  in  1  first cell of packet
in_eof  in  1  last cell of packet
in_eop_len  in  7  valid bytes in eof cell, 1..64; 0 means 64
in_data  in  512  cell; byte 0 at [511:504]
in_ready  out  1  to deparser (tx_ready[p])
m_valid  out  1  MAC beat valid
m_data  out  OUT_W  beat; byte 0 at [OUT_W-1:OUT_W-8]
m_keep  out  OUT_W/8  byte enables; MSB = byte 0; contiguous from MSB
m_sof  out  1  first beat of packet
m_eof  out  1  last beat of packet
m_ready  in  1  MAC accept
pkt_cnt  out  32  packets fully transmitted (m_eof handshakes), wraps
err_cnt  out  16  framing errors, saturates at 0xFFFF

Behaviour:
- Reset: in_ready=0 during reset, 1 on the first cycle after release. m_valid/m_sof/m_eof=0. m_data/m_keep=0. pkt_cnt=0, err_cnt=0. FIFO empty. FSM=IDLE. Reset mid-packet discards all buffered cells; no partial eof is emitted.
- Input: cell written when in_valid && in_ready. in_ready = !full (registered count).
  - Full-and-pop in the same cycle does not raise in_ready until the next cycle (no combinational ready path).
  - FIFO entry stores data, sof, eof, and eop_len normalised to 1..64.
- Framing tracker (input side, flag in_pkt):
  - in_sof while in_pkt=1: err_cnt++, cell accepted as a new packet start.
  - Non-sof cell while in_pkt=0: err_cnt++, cell dropped (not written), in_ready unaffected.
  - A cell with sof and eof both set is a legal single-cell packet.
- Output FSM:
  - IDLE: head present (and release condition met, see Optional Feature) -> STREAM, beat_idx=0.
  - STREAM: drive head cell beat beat_idx.
    - m_sof = head.sof && beat_idx==0.
    - On m_valid && m_ready: beat_idx++.
    - Non-eof cell: after beat BEATS-1, pop; stay STREAM if next head present, else IDLE.
    - Eof cell: last beat = ceil(eop_len*8/OUT_W)-1. m_eof=1 and m_keep has the top ((eop_len-1) mod (OUT_W/8))+1 bits set. Pop, pkt_cnt++, -> IDLE.
  - Non-last beats: m_keep all ones.
- Output latency: cell accepted at cycle N gives m_valid at N+1 (registered head, no fall-through). Back-to-back cells stream with zero bubbles when m_ready is held at 1.
- AXI-style rule: once m_valid=1, m_data/m_keep/m_sof/m_eof hold stable until the handshake.
- Simultaneous push to an empty FIFO and pop of the last entry: the pushed cell becomes head the next cycle, no bubble beyond the 1-cycle latency.
- Pointers are log2(DEPTH)+1 bits, wrap naturally. pkt_cnt wraps at 2^32.

Optional Feature:
- Macro TX_GEARBOX_SAF_EN.
- Defined: store-and-forward.
  - IDLE->STREAM only when the FIFO holds at least one complete packet (complete-packet counter incremented on eof push, decremented on eof pop).
  - If FIFO full with zero complete packets: release in cut-through mode for that packet, err_cnt++.
- Undefined: cut-through. STREAM entered as soon as any cell is present.

Test Plan:
1. Single-cell packet, sof=eof=1, eop_len=64, data bytes 0x00..0x3F, m_ready=1 -> 8 beats (OUT_W=64). First beat 0x0001020304050607 with m_sof. Last beat 0x38..0x3F with m_eof, m_keep=0xFF. pkt_cnt=1.
2. Two-cell packet, second cell eop_len=13 -> 8+2 beats. Final beat m_keep=0xF8, bytes 0x40..0x4C in order. Exactly one m_sof and one m_eof.
3. Backpressure: m_ready toggles 1,0,0,1 repeatedly while 10 packets are pushed back-to-back -> in_ready deasserts when DEPTH=8 cells are buffered. No data loss or reorder. pkt_cnt=10.
4. Framing: sof cell, then sof again without eof -> err_cnt=1. Isolated non-sof cell -> dropped, err_cnt=2, no m_valid from it.
5. Reset asserted mid-STREAM (beat 3) -> next cycle m_valid=0, pkt_cnt=0. After release, a new packet streams correctly from beat 0.
6. With TX_GEARBOX_SAF_EN: push 3 cells of a packet with 5-cycle gaps -> m_valid stays 0 until the cycle after the eof cell is written. A 9-cell packet at DEPTH=8 -> cut-through release, err_cnt=1.

Source files
------------

// File: rtl/tx_port_gearbox.sv
// Per-port egress adapter: buffers 512-bit cells and serialises them into OUT_W-bit MAC beats.
// Define TX_GEARBOX_SAF_EN for store-and-forward release; the default build is cut-through.

module tx_port_gearbox #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned OUT_W = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic               in_sof,
    input  logic               in_eof,
    input  logic [6:0]         in_eop_len,
    input  logic [511:0]       in_data,
    output logic               in_ready,
    output logic               m_valid,
    output logic [OUT_W-1:0]   m_data,
    output logic [OUT_W/8-1:0] m_keep,
    output logic               m_sof,
    output logic               m_eof,
    input  logic               m_ready,
    output logic [31:0]        pkt_cnt,
    output logic [15:0]        err_cnt
);

    localparam int unsigned BEATS = 512 / OUT_W;
    localparam int unsigned BYTES = OUT_W / 8;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned BIW   = $clog2(BEATS);
    localparam int unsigned BSH   = $clog2(BYTES);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    logic [511:0] r_mem_data [DEPTH];
    logic         r_mem_sof  [DEPTH];
    logic         r_mem_eof  [DEPTH];
    logic [6:0]   r_mem_len  [DEPTH];

    logic [AW:0]    r_wptr, r_rptr;
    logic           r_in_ready;
    logic           r_in_pkt;
    logic [BIW-1:0] r_beat_idx;
    state_e         r_state, w_state_nxt;
    logic [31:0]    r_pkt_cnt;
    logic [15:0]    r_err_cnt;

    logic [AW:0]    w_count, w_wptr_nxt, w_rptr_nxt;
    logic           w_empty;
    logic           w_in_fire, w_push, w_frame_err;
    logic [6:0]     w_len_norm;
    logic [511:0]   w_head_data;
    logic           w_head_sof, w_head_eof;
    logic [6:0]     w_head_len;
    logic [5:0]     w_len_m1;
    logic [BIW-1:0] w_last_idx;
    logic           w_last_beat;
    logic [BSH:0]   w_tail_bytes;
    logic [BYTES-1:0] w_tail_keep;
    logic [BEATS-1:0][OUT_W-1:0] w_beats;
    logic           w_release, w_ct_force, w_ct_err;
    logic           w_m_valid, w_out_fire, w_pop;
    logic [1:0]     w_err_inc;
    logic [16:0]    w_err_sum;

    // Input side: framing tracker decides whether an accepted cell is written.
    assign w_count     = r_wptr - r_rptr;
    assign w_empty     = (w_count == '0);
    assign w_in_fire   = in_valid && r_in_ready;
    assign w_frame_err = w_in_fire && (in_sof ? r_in_pkt : !r_in_pkt);
    assign w_push      = w_in_fire && (in_sof || r_in_pkt);
    assign w_len_norm  = (in_eop_len == 7'd0 || in_eop_len > 7'd64) ? 7'd64 : in_eop_len;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wptr[AW-1:0]] <= in_data;
            r_mem_sof[r_wptr[AW-1:0]]  <= in_sof;
            r_mem_eof[r_wptr[AW-1:0]]  <= in_eof;
            r_mem_len[r_wptr[AW-1:0]]  <= w_len_norm;
        end
    end

    // Head cell and beat selection
    assign w_head_data  = r_mem_data[r_rptr[AW-1:0]];
    assign w_head_sof   = r_mem_sof[r_rptr[AW-1:0]];
    assign w_head_eof   = r_mem_eof[r_rptr[AW-1:0]];
    assign w_head_len   = r_mem_len[r_rptr[AW-1:0]];
    assign w_len_m1     = 6'(w_head_len - 7'd1);
    assign w_last_idx   = w_len_m1[5:BSH];
    assign w_last_beat  = w_head_eof ? (r_beat_idx == w_last_idx) : (&r_beat_idx);
    assign w_tail_bytes = {1'b0, w_len_m1[BSH-1:0]} + (BSH+1)'(1);
    assign w_tail_keep  = ~({BYTES{1'b1}} >> w_tail_bytes);
    assign w_beats      = w_head_data;

`ifdef TX_GEARBOX_SAF_EN
    logic [AW:0] r_cpl_cnt;
    logic        r_out_mid;
    logic        w_full;

    assign w_full     = (w_count == FULL_CNT);
    // A full FIFO with no complete packet can never complete one: release it cut-through.
    assign w_ct_force = !w_empty && !r_out_mid && (r_cpl_cnt == '0) && w_full;
    assign w_release  = !w_empty && (r_out_mid || (r_cpl_cnt != '0) || w_full);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cpl_cnt <= '0;
            r_out_mid <= 1'b0;
        end else begin
            r_cpl_cnt <= r_cpl_cnt + (AW+1)'(w_push && in_eof) - (AW+1)'(w_pop && w_head_eof);
            if (w_pop) r_out_mid <= !w_head_eof;
        end
    end
`else
    assign w_ct_force = 1'b0;
    assign w_release  = !w_empty;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_m_valid   = 1'b0;
        w_ct_err    = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_release) begin
                    w_m_valid = 1'b1;
                    w_ct_err  = w_ct_force;
                    if (!(m_ready && w_last_beat)) w_state_nxt = StStream;
                end
            end
            StStream: begin
                w_m_valid = 1'b1;
                if (m_ready && w_last_beat) w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign w_out_fire = w_m_valid && m_ready;
    assign w_pop      = w_out_fire && w_last_beat;
    assign w_wptr_nxt = r_wptr + (AW+1)'(w_push);
    assign w_rptr_nxt = r_rptr + (AW+1)'(w_pop);
    assign w_err_inc  = {1'b0, w_frame_err} + {1'b0, w_ct_err};
    assign w_err_sum  = {1'b0, r_err_cnt} + {15'd0, w_err_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_in_ready <= 1'b0;
            r_in_pkt   <= 1'b0;
            r_beat_idx <= '0;
            r_state    <= StIdle;
            r_pkt_cnt  <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
            r_in_ready <= ((w_wptr_nxt - w_rptr_nxt) != FULL_CNT);
            r_state    <= w_state_nxt;
            if (w_push) r_in_pkt <= !in_eof;
            if (w_pop) r_beat_idx <= '0;
            else if (w_out_fire) r_beat_idx <= r_beat_idx + BIW'(1);
            if (w_pop && w_head_eof) r_pkt_cnt <= r_pkt_cnt + 32'd1;
            r_err_cnt <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    // Outputs are zeroed whenever no beat is presented.
    assign in_ready = r_in_ready;
    assign m_valid  = w_m_valid;
    assign m_data   = w_m_valid ? w_beats[~r_beat_idx] : '0;
    assign m_keep   = !w_m_valid ? '0 : ((w_head_eof && w_last_beat) ? w_tail_keep : '1);
    assign m_sof    = w_m_valid && w_head_sof && (r_beat_idx == '0);
    assign m_eof    = w_m_valid && w_head_eof && w_last_beat;
    assign pkt_cnt  = r_pkt_cnt;
    assign err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_tx_port_gearbox.sv
// Scoreboard bench for tx_port_gearbox: byte-level cell model feeds an expected-beat queue.
// Honours TX_GEARBOX_SAF_EN for the store-and-forward scenarios.

module tb_tx_port_gearbox;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned OUT_W = 64;
    localparam int unsigned BYTES = OUT_W / 8;
    localparam int unsigned BEATS = 512 / OUT_W;

    logic               clk, rst_n;
    logic               in_valid, in_sof, in_eof, in_ready;
    logic [6:0]         in_eop_len;
    logic [511:0]       in_data;
    logic               m_valid, m_sof, m_eof, m_ready;
    logic [OUT_W-1:0]   m_data;
    logic [BYTES-1:0]   m_keep;
    logic [31:0]        pkt_cnt;
    logic [15:0]        err_cnt;

    tx_port_gearbox #(.DEPTH(DEPTH), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof), .in_eop_len(in_eop_len),
        .in_data(in_data), .in_ready(in_ready),
        .m_valid(m_valid), .m_data(m_data), .m_keep(m_keep), .m_sof(m_sof), .m_eof(m_eof),
        .m_ready(m_ready), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [BYTES-1:0] keep;
        logic             sof;
        logic             eof;
        logic             cell_last;
    } beat_t;

    beat_t exp_q[$];
    int    checks = 0, errors = 0;
    int    n_in = 0, n_out = 0, pend_out = 0;
    int    exp_pkts = 0, exp_err = 0;
    int    ready_mode = 0;
    bit    chk_ready = 1'b0, saw_full = 1'b0, m_in_pkt = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [OUT_W-1:0] keep_mask(input logic [BYTES-1:0] k);
        logic [OUT_W-1:0] m;
        for (int j = 0; j < BYTES; j++) m[8*j +: 8] = {8{k[j]}};
        return m;
    endfunction

    // Expected beats for one cell, derived byte-by-byte from the cell framing.
    function automatic void model_cell(input logic [511:0] d, input logic sof, input logic eof,
                                       input int len);
        int nb;
        beat_t e;
        nb = eof ? (len + BYTES - 1) / BYTES : BEATS;
        for (int b = 0; b < nb; b++) begin
            for (int j = 0; j < BYTES; j++) begin
                int k;
                k = b * BYTES + j;
                e.data[OUT_W-1-8*j -: 8] = d[511-8*k -: 8];
                e.keep[BYTES-1-j] = !eof || (k < len);
            end
            e.sof = sof && (b == 0);
            e.eof = eof && (b == nb - 1);
            e.cell_last = (b == nb - 1);
            exp_q.push_back(e);
        end
    endfunction

    function automatic logic [511:0] rand_cell();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [511:0] ramp_cell(input int base);
        logic [511:0] r;
        for (int k = 0; k < 64; k++) r[511-8*k -: 8] = 8'(base + k);
        return r;
    endfunction

    // m_ready driver
    initial begin
        int ph;
        ph = 0;
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: m_ready = 1'b1;
                1: begin m_ready = (ph % 4 == 0) || (ph % 4 == 3); ph++; end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: in_ready vs. bench occupancy, beats vs. scoreboard.
    initial begin
        beat_t e;
        logic [OUT_W-1:0] mk;
        forever begin
            @(negedge clk);
            n_out += pend_out;
            pend_out = 0;
            if (chk_ready) begin
                check("in_ready", 64'(in_ready), 64'((n_in - n_out) != DEPTH));
                if (!in_ready) saw_full = 1'b1;
            end
            if (m_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data 0x%0h, expected no beat", m_data);
                end else begin
                    e = exp_q[0];
                    mk = keep_mask(e.keep);
                    check("beat_data", 64'(m_data & mk), 64'(e.data & mk));
                    check("beat_ctl", 64'({m_keep, m_sof, m_eof}), 64'({e.keep, e.sof, e.eof}));
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        pend_out = int'(e.cell_last);
                    end
                end
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the cell is taken (or the bound expires).
    task automatic send_cell(input logic [511:0] d, input logic sof, input logic eof,
                             input logic [6:0] len_raw);
        int budget, len;
        bit push;
        budget = 0;
        push = 1'b0;
        in_data = d;
        in_sof = sof;
        in_eof = eof;
        in_eop_len = len_raw;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && budget < 2000) begin
            budget++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at 0, expected 1");
        end else begin
            len = (len_raw == 7'd0 || len_raw > 7'd64) ? 64 : int'(len_raw);
            if (sof || m_in_pkt) begin
                if (sof && m_in_pkt) exp_err++;
                model_cell(d, sof, eof, len);
                push = 1'b1;
                m_in_pkt = !eof;
                if (eof) exp_pkts++;
            end else begin
                exp_err++;
            end
        end
        @(posedge clk);
        if (push) n_in++;
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_pkt(input int ncells, input int gap_max);
        for (int c = 0; c < ncells; c++) begin
            send_cell(rand_cell(), c == 0, c == ncells - 1, 7'($urandom_range(0, 64)));
            repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || m_valid) && budget < 4000) begin
            budget++;
            @(negedge clk);
        end
        check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_pkt_cnt"}, 64'(pkt_cnt), 64'(exp_pkts));
        check({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_sof = 1'b0;
        in_eof = 1'b0;
        in_eop_len = '0;
        in_data = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_m_keep", 64'(m_keep), 64'd0);
        check("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
        check("rst_err_cnt", 64'(err_cnt), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_ready = 1'b1;

        // Single-cell packet, ramp bytes, one-cycle latency
        send_cell(ramp_cell(0), 1'b1, 1'b1, 7'd64);
        @(negedge clk);
        check("t1_latency_valid", 64'(m_valid), 64'd1);
        check("t1_first_beat", 64'(m_data), 64'h0001020304050607);
        check("t1_first_sof", 64'(m_sof), 64'd1);
        drain("t1");

        // Two-cell packet, short tail
        send_cell(ramp_cell(0), 1'b1, 1'b0, 7'd0);
        send_cell(ramp_cell(8'h40), 1'b0, 1'b1, 7'd13);
        drain("t2");

        // Back-to-back packets under 1,0,0,1 backpressure
        ready_mode = 1;
        saw_full = 1'b0;
        for (int p = 0; p < 10; p++) send_pkt($urandom_range(1, 3), 0);
        drain("t3");
        check("t3_in_ready_dropped", 64'(saw_full), 64'd1);
        ready_mode = 0;

        // Framing errors
        send_cell(rand_cell(), 1'b1, 1'b0, 7'd0);
        send_cell(rand_cell(), 1'b1, 1'b1, 7'd20);
        drain("t4a");
        send_cell(rand_cell(), 1'b0, 1'b1, 7'd9);
        drain("t4b");

        // Reset while beat 3 of a packet is presented
        send_cell(rand_cell(), 1'b1, 1'b1, 7'd64);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        chk_ready = 1'b0;
        exp_q.delete();
        n_in = 0;
        n_out = 0;
        pend_out = 0;
        exp_pkts = 0;
        exp_err = 0;
        m_in_pkt = 1'b0;
        @(negedge clk);
        check("t5_reset_m_valid", 64'(m_valid), 64'd0);
        check("t5_reset_pkt_cnt", 64'(pkt_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk_ready = 1'b1;
        send_pkt(2, 0);
        drain("t5");

`ifdef TX_GEARBOX_SAF_EN
        // Store-and-forward: nothing leaves before the eof cell is written
        for (int c = 0; c < 3; c++) begin
            send_cell(rand_cell(), c == 0, c == 2, 7'd30);
            if (c < 2) begin
                for (int g = 0; g < 5; g++) begin
                    @(negedge clk);
                    check("t6_saf_hold", 64'(m_valid), 64'd0);
                end
                @(posedge clk);
                #1;
            end
        end
        @(negedge clk);
        check("t6_saf_release", 64'(m_valid), 64'd1);
        drain("t6a");
        exp_err++;
`endif

        // Packet longer than the FIFO
        send_pkt(9, 0);
        drain("t6b");

        // Randomised traffic with random gaps and backpressure
        ready_mode = 2;
        for (int p = 0; p < 20; p++) send_pkt($urandom_range(1, 4), 3);
        drain("t7");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
